// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  localparam logic [3:0] IMEM_MASK_ALL = 4'b1111;
  localparam int         INST_BYTES    = 4;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO: power-of-two ring buffer with wrap-bit pointers and a synchronous flush.
module prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign count = r_wr_ptr - r_rd_ptr;
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (count == DEPTH_CNT);
  assign dout  = r_mem[r_rd_ptr[AW-1:0]];

  // At full a push is only taken together with a pop; the popped slot is the one written.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// RV32I fetch front end: PC generation, single-outstanding imem handshake, prefetch buffering.
// Optional perf counters are compiled in when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_request,
  output logic              imem_we_re,
  output logic [3:0]        imem_mask,
  output logic [XLEN-1:0]   imem_address,
  input  logic              imem_valid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  input  logic              dec_ready,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [XLEN-1:0]   inst_pc,
  output fetch_state_e      o_dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  // Handshake: imem_request/imem_address are held until the single in-flight request sees
  // imem_valid; a redirect may drop imem_request early but the owed response is still absorbed.
  // Decode side: the head entry transfers on any cycle with inst_valid & dec_ready & !redirect_valid.

  fetch_state_e        r_state;
  logic [XLEN-1:0]     r_fetch_pc;
  logic                r_req;
  logic [XLEN-1:0]     r_addr;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_count_after;
  logic                w_slot_free;
  logic [XLEN-1:0]     w_redirect_pc;
  logic [XLEN-1:0]     w_pc_plus;
  logic [XLEN+31:0]    w_din;
  logic [XLEN+31:0]    w_dout;

  assign w_redirect_pc = redirect_pc & ~XLEN'(3);
  assign w_pc_plus     = r_fetch_pc + XLEN'(INST_BYTES);
  assign w_push        = (r_state == WAIT) & imem_valid & ~redirect_valid;
  assign w_pop         = ~w_empty & dec_ready & ~redirect_valid;
  assign w_din         = {r_fetch_pc, imem_rdata};
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_slot_free   = (w_count_after < DEPTH_CNT);

  prefetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (redirect_valid),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (!w_full) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
            r_addr  <= r_fetch_pc;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            // A response arriving with the redirect is simply dropped; otherwise it is still owed.
            r_fetch_pc <= w_redirect_pc;
            r_req      <= 1'b0;
            r_state    <= imem_valid ? IDLE : DROP;
          end else if (imem_valid) begin
            r_fetch_pc <= w_pc_plus;
            if (w_slot_free) begin
              r_addr <= w_pc_plus;
            end else begin
              r_req   <= 1'b0;
              r_state <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_valid) r_fetch_pc <= w_redirect_pc;
          if (imem_valid)     r_state    <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_request = r_req;
  assign imem_address = r_addr;
  assign imem_we_re   = 1'b0;
  assign imem_mask    = IMEM_MASK_ALL;
  assign inst_valid   = ~w_empty;
  assign inst_out     = w_empty ? 32'd0 : w_dout[31:0];
  assign inst_pc      = w_empty ? '0 : w_dout[XLEN+31:32];
  assign o_dbg_state  = r_state;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_push)         r_perf_fetch <= r_perf_fetch + 32'd1;
      if (redirect_valid) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch;
  assign perf_flush_cnt = r_perf_flush;
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: latency-programmable memory model, expected-queue scoreboard.
module tb_fetch_prefetch_unit;
  import fetch_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_request;
  logic        imem_we_re;
  logic [3:0]  imem_mask;
  logic [31:0] imem_address;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  fetch_state_e dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  fetch_prefetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_request   (imem_request),
    .imem_we_re     (imem_we_re),
    .imem_mask      (imem_mask),
    .imem_address   (imem_address),
    .imem_valid     (imem_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_ready      (dec_ready),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .o_dbg_state    (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[19:0], 12'h013};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          lat = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          n_req;

  initial begin
    imem_valid = 1'b0;
    imem_rdata = '0;
    mem_busy   = 1'b0;
    mem_cnt    = 0;
    mem_addr   = '0;
    n_req      = 0;
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      mem_busy   = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = '0;
    end else begin
      if (imem_valid) begin
        imem_valid = 1'b0;
        mem_busy   = 1'b0;
      end
      if (imem_request && mem_busy) check("addr_stable", imem_address, mem_addr);
      if (imem_request && !mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = imem_address;
        mem_cnt  = lat;
        n_req++;
      end
      if (mem_busy) begin
        if (mem_cnt <= 1) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
        end else begin
          mem_cnt--;
        end
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #4;
    if (rst && inst_valid && dec_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc %h inst %h, expected nothing", inst_pc, inst_out);
      end else begin
        check("head_pc_inst", {inst_pc, inst_out}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  task automatic hold_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_ready      = 1'b0;
    repeat (3) tick();
    n_req = 0;
  endtask

  task automatic wait_addr(input logic [31:0] addr, input int max);
    int k;
    k = 0;
    while (!(imem_request && imem_address == addr) && k < max) begin
      tick();
      k++;
    end
    check("wait_addr_seen", {31'd0, imem_request && imem_address == addr}, 64'd1);
  endtask

  task automatic first_req(input logic [31:0] addr, input int max);
    int k;
    k = 0;
    while (!imem_request && k < max) begin
      tick();
      k++;
    end
    check("first_req_addr", {imem_request, imem_address}, {1'b1, addr});
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    dec_ready = 1'b1;
    while (exp_q.size() != 0 && k < max) begin
      tick();
      k++;
    end
    dec_ready = 1'b0;
    check("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hold_reset();
    // Reset values, no edge needed
    check("rst_req", imem_request, 0);
    check("rst_addr", imem_address, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst_out, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("we_re", imem_we_re, 0);
    check("mask", imem_mask, 4'hF);

    // 1: sequential fetch, 1-cycle memory, decode always ready
    lat = 1;
    for (int i = 0; i < 8; i++) expect_pc(32'(i * 4));
    dec_ready = 1'b1;
    rst = 1'b1;
    first_req(32'h0, 10);
    @(negedge clk);
    check("no_bypass", inst_valid, 0);
    tick();
    check("first_valid", inst_valid, 1);
    drain(60);

    // 2: backpressure fills the FIFO, one pop releases the next request
    hold_reset();
    lat = 1;
    expect_pc(32'h0);
    rst = 1'b1;
    repeat (10) tick();
    check("full_no_req", imem_request, 0);
    check("full_req_count", 64'(n_req), 64'd4);
    check("full_state", 64'(dbg_state), 64'(IDLE));
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    wait_addr(32'h10, 5);
    check("resume_count", 64'(n_req), 64'd5);
    expect_pc(32'h4);
    expect_pc(32'h8);
    expect_pc(32'hC);
    expect_pc(32'h10);
    expect_pc(32'h14);
    drain(40);

    // 3: redirect while 0x8 waits on a 3-cycle memory
    hold_reset();
    lat = 3;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h100);
    expect_pc(32'h104);
    expect_pc(32'h108);
    dec_ready = 1'b1;
    rst = 1'b1;
    wait_addr(32'h8, 30);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("drop_state", 64'(dbg_state), 64'(DROP));
    check("drop_req", imem_request, 0);
    wait_addr(32'h100, 20);
    drain(60);

    // 4: redirect coincident with the 0x4 response; low bits of target ignored
    hold_reset();
    lat = 2;
    expect_pc(32'h0);
    expect_pc(32'h200);
    expect_pc(32'h204);
    dec_ready = 1'b1;
    rst = 1'b1;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!(imem_request && imem_address == 32'h4 && imem_valid) && k < 30);
      check("resp_for_4_seen", {31'd0, imem_valid && imem_address == 32'h4}, 64'd1);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid_state", 64'(dbg_state), 64'(IDLE));
    check("redir_no_req", imem_request, 0);
    tick();
    check("redir_addr", {imem_request, imem_address}, {1'b1, 32'h200});
    drain(40);

    // 5: asynchronous reset in the middle of the 0xC request
    hold_reset();
    lat = 2;
    expect_pc(32'h0);
    expect_pc(32'h4);
    expect_pc(32'h8);
    dec_ready = 1'b1;
    rst = 1'b1;
    wait_addr(32'hC, 30);
    tick();
    check("pre_reset_q", 64'(exp_q.size()), 64'd0);
    #1;
    rst = 1'b0;
    #1;
    check("arst_req", imem_request, 0);
    check("arst_addr", imem_address, 0);
    check("arst_valid", inst_valid, 0);
    check("arst_inst", inst_out, 0);
    check("arst_pc", inst_pc, 0);
    check("arst_state", 64'(dbg_state), 64'(IDLE));
    dec_ready = 1'b0;
    repeat (3) tick();
    expect_pc(32'h0);
    expect_pc(32'h4);
    dec_ready = 1'b1;
    rst = 1'b1;
    first_req(32'h0, 10);
    drain(40);

`ifdef FETCH_PERF_CNT_EN
    // 6: perf counters over three fills and two redirects
    hold_reset();
    lat = 1;
    check("perf_rst_fetch", perf_fetch_cnt, 0);
    check("perf_rst_flush", perf_flush_cnt, 0);
    rst = 1'b1;
    repeat (10) tick();
    check("perf_fill1", perf_fetch_cnt, 4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    check("perf_head_40", inst_pc, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    repeat (10) tick();
    check("perf_fetch", perf_fetch_cnt, 12);
    check("perf_flush", perf_flush_cnt, 2);
    check("perf_head_80", inst_pc, 32'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
